sorted_frame_stats: RTL and testbench

- Downstream consumer of the pixel-sum sorter's serial result stream. The sorter emits 8 sorted 6-bit sums, one per cycle, under out_valid.
- This block collects each 8-beat frame and reports, one cycle after the last beat, a single-cycle summary: sum, min, max, median, range and an ordering-check flag.
- It also detects frames that stall mid-stream and aborts them, so a broken upstream cannot wedge the stats path.

---
 rtl/stats_pkg.sv | 14 +
 rtl/frame_beat_tracker.sv | 47 ++++
 rtl/sorted_frame_stats.sv | 118 +++++++++++
 tb/tb_sorted_frame_stats.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stats_pkg.sv
// Shared defaults and FSM encoding for the sorted-frame statistics path.
package stats_pkg;
    localparam int DEF_N       = 8;
    localparam int DEF_DW      = 6;
    localparam int DEF_TIMEOUT = 16;
    localparam int SUMW        = DEF_DW + $clog2(DEF_N);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        REPORT,
        ABORT
    } state_t;
endpackage

// File: rtl/frame_beat_tracker.sv
// Beat position within a frame plus the idle-gap watchdog.
module frame_beat_tracker #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    input  logic gap,
    output logic last_beat,
    output logic med_lo_hit,
    output logic med_hi_hit,
    output logic timeout
);
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] beat_idx;
    logic [IW-1:0] idle;

    // Index of the beat being accepted this cycle; a load is always beat 0.
    assign beat_idx   = load ? '0 : count;
    assign med_lo_hit = (load || step) && (beat_idx == CW'(N/2 - 1));
    assign med_hi_hit = (load || step) && (beat_idx == CW'(N/2));
    assign last_beat  = step && (count == CW'(N - 1));
    assign timeout    = gap && (idle == IW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            idle  <= '0;
        end else if (load) begin
            count <= CW'(1);
            idle  <= '0;
        end else if (step) begin
            count <= count + CW'(1);
            idle  <= '0;
        end else if (gap) begin
            idle  <= idle + IW'(1);
        end else begin
            count <= '0;
            idle  <= '0;
        end
    end
endmodule

// File: rtl/sorted_frame_stats.sv
// Collects N-beat frames from the sorter and emits a one-cycle statistics summary.
module sorted_frame_stats
    import stats_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DW-1:0]             in_data,
    input  logic                      in_valid,
    output logic [DW+$clog2(N)-1:0]   sum_out,
    output logic [DW-1:0]             min_out,
    output logic [DW-1:0]             max_out,
    output logic [DW-1:0]             med_out,
    output logic [DW-1:0]             range_out,
    output logic                      order_err,
    output logic                      stat_valid,
    output logic                      frame_err
);
    localparam int SW = DW + $clog2(N);

    state_t        state, state_nx;
    logic          accept, load, step, gap;
    logic          last_beat, med_lo_hit, med_hi_hit, timeout;
    logic [SW-1:0] sum_acc;
    logic [DW-1:0] min_acc, max_acc, prev, med_lo, med_hi;
    logic          ord_acc;
    logic [DW:0]   med_sum;

    // An X on in_valid must never count as a beat.
    assign accept = (in_valid === 1'b1);
    assign load   = accept && (state != ACCUM);
    assign step   = accept && (state == ACCUM);
    assign gap    = (state == ACCUM) && !accept;

    frame_beat_tracker #(.N(N), .TIMEOUT(TIMEOUT)) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .step       (step),
        .gap        (gap),
        .last_beat  (last_beat),
        .med_lo_hit (med_lo_hit),
        .med_hi_hit (med_hi_hit),
        .timeout    (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ACCUM;
            ACCUM: begin
                if (last_beat)    state_nx = REPORT;
                else if (timeout) state_nx = ABORT;
            end
            REPORT:  state_nx = accept ? ACCUM : IDLE;
            ABORT:   state_nx = accept ? ACCUM : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (state == ABORT && !load)) begin
            sum_acc <= '0;
            min_acc <= '0;
            max_acc <= '0;
            prev    <= '0;
            ord_acc <= 1'b0;
            med_lo  <= '0;
            med_hi  <= '0;
        end else if (load) begin
            sum_acc <= SW'(in_data);
            min_acc <= in_data;
            max_acc <= in_data;
            prev    <= in_data;
            ord_acc <= 1'b0;
            if (med_lo_hit) med_lo <= in_data;
            if (med_hi_hit) med_hi <= in_data;
        end else if (step) begin
            sum_acc <= sum_acc + SW'(in_data);
            if (in_data < min_acc) min_acc <= in_data;
            if (in_data > max_acc) max_acc <= in_data;
            if (in_data < prev)    ord_acc <= 1'b1;
            prev <= in_data;
            if (med_lo_hit) med_lo <= in_data;
            if (med_hi_hit) med_hi <= in_data;
        end
    end

    assign med_sum = {1'b0, med_lo} + {1'b0, med_hi};

    // Outputs are gated by REPORT so nothing stale leaks between frames.
    always_comb begin
        sum_out    = '0;
        min_out    = '0;
        max_out    = '0;
        med_out    = '0;
        range_out  = '0;
        order_err  = 1'b0;
        stat_valid = (state == REPORT);
        frame_err  = (state == ABORT);
        if (state == REPORT) begin
            sum_out   = sum_acc;
            min_out   = min_acc;
            max_out   = max_acc;
            med_out   = med_sum[DW:1];
            range_out = max_acc - min_acc;
            order_err = ord_acc;
        end
    end
endmodule

// File: tb/tb_sorted_frame_stats.sv
// Self-checking bench: directed frame table, reset/back-to-back sequence, random traffic vs frame model.
module tb_sorted_frame_stats;
    localparam int N = 8;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic       sv;
        logic       fe;
        logic [8:0] sum;
        logic [5:0] mn;
        logic [5:0] mx;
        logic [5:0] md;
        logic [5:0] rg;
        logic       oe;
    } outs_t;

    typedef struct {
        logic [47:0] beats;
        int          gap_at;
        int          gap_len;
        logic        e_err;
        logic [8:0]  e_sum;
        logic [5:0]  e_min;
        logic [5:0]  e_max;
        logic [5:0]  e_med;
        logic [5:0]  e_rng;
        logic        e_ord;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] in_data;
    logic       in_valid;
    logic [8:0] sum_out;
    logic [5:0] min_out, max_out, med_out, range_out;
    logic       order_err, stat_valid, frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    outs_t cur, exp_o;
    int    q[$];
    int    idle_cnt;

    always #5 clk = ~clk;

    sorted_frame_stats dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .sum_out    (sum_out),
        .min_out    (min_out),
        .max_out    (max_out),
        .med_out    (med_out),
        .range_out  (range_out),
        .order_err  (order_err),
        .stat_valid (stat_valid),
        .frame_err  (frame_err)
    );

    function automatic logic [47:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {6'(a7), 6'(a6), 6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame-level reference: a frame is just the list of beats seen so far.
    function automatic outs_t frame_stats(input int b[$]);
        outs_t o;
        int s, mn, mx;
        logic ord;
        s = 0; mn = b[0]; mx = b[0]; ord = 1'b0;
        foreach (b[i]) begin
            s += b[i];
            if (b[i] < mn) mn = b[i];
            if (b[i] > mx) mx = b[i];
            if (i > 0 && b[i] < b[i-1]) ord = 1'b1;
        end
        o.sv  = 1'b1;
        o.fe  = 1'b0;
        o.sum = 9'(s);
        o.mn  = 6'(mn);
        o.mx  = 6'(mx);
        o.md  = 6'((b[N/2-1] + b[N/2]) / 2);
        o.rg  = 6'(mx - mn);
        o.oe  = ord;
        return o;
    endfunction

    task automatic model_edge(input logic v, input logic [5:0] d, input logic r);
        exp_o = '0;
        if (r) begin
            q.delete();
            idle_cnt = 0;
        end else if (v) begin
            q.push_back(int'(d));
            idle_cnt = 0;
            if (q.size() == N) begin
                exp_o = frame_stats(q);
                q.delete();
            end
        end else if (q.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT) begin
                exp_o.fe = 1'b1;
                q.delete();
                idle_cnt = 0;
            end
        end
    endtask

    task automatic run_cycle(input logic v, input logic [5:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        rst      = r;
        @(posedge clk);
        model_edge(v, d, r);
        cyc++;
        #1;
        cur = '{stat_valid, frame_err, sum_out, min_out, max_out, med_out, range_out, order_err};
        check("cycle_outputs", 64'(cur), 64'(exp_o));
    endtask

    vec_t vt[6];
    int   pulses[$];
    int   sums[$];
    logic saw_err, saw_sv;

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        rst      = 1'b1;
        idle_cnt = 0;

        vt[0] = '{pk(0,1,2,3,4,5,6,7),         0, 0,  1'b0, 9'd28,  6'd0,  6'd7,  6'd3,  6'd7,  1'b0};
        vt[1] = '{pk(62,62,62,62,62,62,62,62), 0, 0,  1'b0, 9'd496, 6'd62, 6'd62, 6'd62, 6'd0,  1'b0};
        vt[2] = '{pk(9,3,40,40,2,63,10,11),    0, 0,  1'b0, 9'd178, 6'd2,  6'd63, 6'd21, 6'd61, 1'b1};
        vt[3] = '{pk(0,1,2,3,4,5,6,7),         4, 5,  1'b0, 9'd28,  6'd0,  6'd7,  6'd3,  6'd7,  1'b0};
        vt[4] = '{pk(0,1,2,3,4,5,6,7),         4, 16, 1'b1, 9'd0,   6'd0,  6'd0,  6'd0,  6'd0,  1'b0};
        vt[5] = '{pk(0,1,2,3,4,5,6,7),         0, 0,  1'b0, 9'd28,  6'd0,  6'd7,  6'd3,  6'd7,  1'b0};

        repeat (2) run_cycle(1'b0, 6'd0, 1'b1);
        check("reset_outputs", 64'(cur), 64'd0);
        run_cycle(1'b0, 6'd0, 1'b0);

        foreach (vt[k]) begin
            saw_err = 1'b0;
            saw_sv  = 1'b0;
            for (int i = 0; i < N; i++) begin
                run_cycle(1'b1, vt[k].beats[i*6 +: 6], 1'b0);
                saw_sv |= cur.sv;
                if (i + 1 == vt[k].gap_at) begin
                    for (int g = 0; g < vt[k].gap_len; g++) begin
                        run_cycle(1'b0, 6'd0, 1'b0);
                        saw_err |= cur.fe;
                        saw_sv  |= cur.sv;
                    end
                    if (vt[k].e_err) break;
                end
            end
            if (vt[k].e_err) begin
                check("vec_abort_flags", {62'd0, saw_err, saw_sv}, 64'b10);
            end else begin
                check("vec_stats", 64'(cur),
                      64'(outs_t'{1'b1, 1'b0, vt[k].e_sum, vt[k].e_min, vt[k].e_max,
                                  vt[k].e_med, vt[k].e_rng, vt[k].e_ord}));
            end
            repeat (2) run_cycle(1'b0, 6'd0, 1'b0);
        end

        // Partial frame then reset: nothing of it may surface later.
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 6'd50, 1'b0);
        for (int i = 0; i < 2; i++) begin
            run_cycle(1'b1, 6'd33, 1'b1);
            check("mid_frame_reset_zero", 64'(cur), 64'd0);
        end
        for (int i = 0; i < 2 * N; i++) begin
            run_cycle(1'b1, (i < N) ? 6'(i) : 6'(i + 2), 1'b0);
            if (cur.sv) begin
                pulses.push_back(cyc);
                sums.push_back(int'(cur.sum));
            end
        end
        check("b2b_pulse_count", 64'(pulses.size()), 64'd2);
        if (pulses.size() == 2) begin
            check("b2b_spacing", 64'(pulses[1] - pulses[0]), 64'd8);
            check("b2b_sum_first", 64'(sums[0]), 64'd28);
            check("b2b_sum_second", 64'(sums[1]), 64'd108);
        end
        repeat (3) run_cycle(1'b0, 6'd0, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                run_cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'b1);
            end else if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(10, 20)) run_cycle(1'b0, 6'd0, 1'b0);
            end else begin
                run_cycle(($urandom_range(0, 9) < 7), 6'($urandom_range(0, 63)), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
